// File: rtl/hmm_emission_sequencer_pkg.sv
// Shared constants and types for the HMM emission sequencer.
// Imported by the interface, the table and the top.
package hmm_pkg;

  localparam int N_STATES = 4;
  localparam int PROB_W   = 32;
  localparam int ACC_W    = 64;
  localparam int STEP_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_OUT
  } state_e;

  typedef logic [N_STATES-1:0][PROB_W-1:0] bk_vec_t;

endpackage

// File: rtl/hmm_emission_sequencer_if.sv
// Observation input stream and result output stream of the sequencer.
// master = environment side, slave = sequencer side.
interface hmm_emission_sequencer_if
  import hmm_pkg::*;
#(
  parameter int SYM_W = 2
);

  logic               obs_valid;
  logic               obs_ready;
  logic [SYM_W-1:0]   obs_sym;
  logic               obs_last;
  logic               res_valid;
  logic               res_ready;
  logic [ACC_W-1:0]   res_max;
  logic [STEP_W-1:0]  res_step;
  logic               res_last;

  modport master (
    output obs_valid, obs_sym, obs_last, res_ready,
    input  obs_ready, res_valid, res_max, res_step, res_last
  );

  modport slave (
    input  obs_valid, obs_sym, obs_last, res_ready,
    output obs_ready, res_valid, res_max, res_step, res_last
  );

endinterface

// File: rtl/hmm_emission_sequencer_table.sv
// Emission table: 4 rows x NSYM columns, one write port, 4-wide read.
// Out-of-range writes are dropped; out-of-range reads return 0.
module hmm_emission_table
  import hmm_pkg::*;
#(
  parameter int NSYM  = 4,
  parameter int SYM_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [1:0]        wstate,
  input  logic [SYM_W-1:0]  wsym,
  input  logic [PROB_W-1:0] wdata,
  input  logic [SYM_W-1:0]  rsym,
  output bk_vec_t           rdata
);

  bk_vec_t mem [NSYM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSYM; i++) begin
        mem[i] <= '0;
      end
    end else if (we && int'(wsym) < NSYM) begin
      mem[wsym][wstate] <= wdata;
    end
  end

  assign rdata = (int'(rsym) < NSYM) ? mem[rsym] : '0;

endmodule

// File: rtl/hmm_emission_sequencer.sv
// Feeds emission probabilities to the HMM array, one symbol at a time,
// and returns the settled max per step. Option: HMM_SEQ_PEAK_EN.
module hmm_emission_sequencer
  import hmm_pkg::*;
#(
  parameter int NSYM   = 4,
  parameter int SYM_W  = 2,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_state,
  input  logic [SYM_W-1:0]  cfg_sym,
  input  logic [PROB_W-1:0] cfg_data,
  hmm_emission_sequencer_if.slave io,
  output logic [PROB_W-1:0] bk1,
  output logic [PROB_W-1:0] bk2,
  output logic [PROB_W-1:0] bk3,
  output logic [PROB_W-1:0] bk4,
  input  logic [ACC_W-1:0]  max_in,
  output logic              sym_err,
  output logic              busy
`ifdef HMM_SEQ_PEAK_EN
  ,
  output logic [ACC_W-1:0]  peak_max,
  output logic [STEP_W-1:0] peak_step
`endif
);

  localparam int CW = $clog2(SETTLE + 1);

  state_e             state;
  state_e             nxt;
  logic [SYM_W-1:0]   sym_q;
  logic               last_q;
  logic [CW-1:0]      cnt;
  logic [ACC_W-1:0]   max_q;
  logic [STEP_W-1:0]  step_q;
  bk_vec_t            rd;
  logic               accept;
  logic               hs;
  logic               settled;

  assign accept  = io.obs_valid && (state == ST_IDLE);
  assign hs      = io.res_ready && (state == ST_OUT);
  assign settled = (cnt == CW'(SETTLE));

  assign io.obs_ready = (state == ST_IDLE);
  assign io.res_valid = (state == ST_OUT);
  assign io.res_max   = max_q;
  assign io.res_step  = step_q;
  assign io.res_last  = last_q;
  assign busy         = (state != ST_IDLE);

  hmm_emission_table #(
    .NSYM  (NSYM),
    .SYM_W (SYM_W)
  ) u_table (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (cfg_we && !busy),
    .wstate (cfg_state),
    .wsym   (cfg_sym),
    .wdata  (cfg_data),
    .rsym   (sym_q),
    .rdata  (rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:   if (io.obs_valid) nxt = ST_LOAD;
      ST_LOAD:   nxt = ST_SETTLE;
      ST_SETTLE: if (settled) nxt = ST_OUT;
      ST_OUT:    if (io.res_ready) nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // SETTLE lasts SETTLE+1 cycles so bk is stable SETTLE full cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_q   <= '0;
      last_q  <= 1'b0;
      cnt     <= '0;
      max_q   <= '0;
      step_q  <= '0;
      sym_err <= 1'b0;
      bk1     <= '0;
      bk2     <= '0;
      bk3     <= '0;
      bk4     <= '0;
    end else begin
      if (accept) begin
        sym_q  <= io.obs_sym;
        last_q <= io.obs_last;
        if (int'(io.obs_sym) >= NSYM) sym_err <= 1'b1;
      end
      if (state == ST_LOAD) begin
        bk1 <= rd[0];
        bk2 <= rd[1];
        bk3 <= rd[2];
        bk4 <= rd[3];
        cnt <= '0;
      end
      if (state == ST_SETTLE) begin
        cnt <= cnt + CW'(1);
        if (settled) max_q <= max_in;
      end
      if (hs) begin
        step_q <= last_q ? '0 : step_q + STEP_W'(1);
      end
    end
  end

`ifdef HMM_SEQ_PEAK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_max  <= '0;
      peak_step <= '0;
    end else if (hs && (step_q == '0 || max_q > peak_max)) begin
      peak_max  <= max_q;
      peak_step <= step_q;
    end
  end
`endif

endmodule

// File: tb/tb_hmm_emission_sequencer.sv
// Randomized directed bench for hmm_emission_sequencer (NSYM=3)
// against a table/step/peak reference model.
module tb_hmm_emission_sequencer;
  import hmm_pkg::*;

  localparam int NSYM   = 3;
  localparam int SYM_W  = 2;
  localparam int SETTLE = 2;
  localparam int LAT    = SETTLE + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_state = '0;
  logic [SYM_W-1:0]  cfg_sym = '0;
  logic [31:0]       cfg_data = '0;
  logic [31:0]       bk1, bk2, bk3, bk4;
  logic [63:0]       max_in;
  logic [63:0]       max_drv = '0;
  logic              sym_err, busy;
`ifdef HMM_SEQ_PEAK_EN
  logic [63:0]       peak_max;
  logic [7:0]        peak_step;
`endif

  always #5 clk = ~clk;
  assign max_in = max_drv;

  hmm_emission_sequencer_if #(.SYM_W(SYM_W)) io ();

  hmm_emission_sequencer #(
    .NSYM   (NSYM),
    .SYM_W  (SYM_W),
    .SETTLE (SETTLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_state (cfg_state),
    .cfg_sym   (cfg_sym),
    .cfg_data  (cfg_data),
    .io        (io),
    .bk1       (bk1),
    .bk2       (bk2),
    .bk3       (bk3),
    .bk4       (bk4),
    .max_in    (max_in),
    .sym_err   (sym_err),
    .busy      (busy)
`ifdef HMM_SEQ_PEAK_EN
    ,
    .peak_max  (peak_max),
    .peak_step (peak_step)
`endif
  );

  int          total = 0;
  int          passed = 0;
  int          fails = 0;
  logic [31:0] tbl [4][NSYM];
  int          exp_step = 0;
  bit          exp_err = 0;
  logic [63:0] exp_peak = '0;
  int          exp_pstep = 0;
  bit          force_mode = 0;
  logic [63:0] force_val = '0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    total++;
    assert (got === want) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] sx(logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // the array: max of two pairwise two's-complement sums, unsigned compare
  function automatic logic [63:0] arr_model(logic [31:0] a, logic [31:0] b,
                                            logic [31:0] c, logic [31:0] d);
    logic [63:0] s1, s2;
    s1 = sx(a) + sx(b);
    s2 = sx(c) + sx(d);
    return (s1 > s2) ? s1 : s2;
  endfunction

  function automatic logic [31:0] exp_bk(int j, int s);
    if (s < NSYM) return tbl[j][s];
    return 32'd0;
  endfunction

  task automatic clear_model();
    for (int j = 0; j < 4; j++)
      for (int s = 0; s < NSYM; s++)
        tbl[j][s] = '0;
    exp_step = 0;
    exp_err  = 0;
    exp_peak = '0;
    exp_pstep = 0;
  endtask

  task automatic check_reset_vals();
    chk("rst_bk1", 64'(bk1), 64'(0));
    chk("rst_bk2", 64'(bk2), 64'(0));
    chk("rst_bk3", 64'(bk3), 64'(0));
    chk("rst_bk4", 64'(bk4), 64'(0));
    chk("rst_res_valid", 64'(io.res_valid), 64'(0));
    chk("rst_res_max", io.res_max, 64'(0));
    chk("rst_res_step", 64'(io.res_step), 64'(0));
    chk("rst_res_last", 64'(io.res_last), 64'(0));
    chk("rst_sym_err", 64'(sym_err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_obs_ready", 64'(io.obs_ready), 64'(1));
  endtask

  task automatic cfg_write(int j, int s, logic [31:0] d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_state = 2'(j);
    cfg_sym   = SYM_W'(s);
    cfg_data  = d;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    if (s < NSYM) tbl[j][s] = d;
  endtask

  task automatic run_obs(int s, bit last, int stall,
                         bit wr_same, int wr_j, logic [31:0] wr_d);
    logic [31:0] e [4];
    logic [63:0] emax;
    int          lat;
    @(negedge clk);
    chk("obs_ready_idle", 64'(io.obs_ready), 64'(1));
    io.obs_valid = 1'b1;
    io.obs_sym   = SYM_W'(s);
    io.obs_last  = last;
    if (wr_same) begin
      cfg_we    = 1'b1;
      cfg_state = 2'(wr_j);
      cfg_sym   = SYM_W'(s);
      cfg_data  = wr_d;
      if (s < NSYM) tbl[wr_j][s] = wr_d;
    end
    @(posedge clk);
    @(negedge clk);
    io.obs_valid = 1'b0;
    cfg_we       = 1'b0;
    if (s >= NSYM) exp_err = 1;
    for (int j = 0; j < 4; j++) e[j] = exp_bk(j, s);
    emax = force_mode ? force_val : arr_model(e[0], e[1], e[2], e[3]);
    chk("busy_inflight", 64'(busy), 64'(1));
    chk("obs_ready_busy", 64'(io.obs_ready), 64'(0));
    // max_in is only correct on the cycle before the sampling edge
    max_drv = {$urandom, $urandom};
    lat = 0;
    while (io.res_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      max_drv = (lat == LAT - 1) ? emax : {$urandom, $urandom};
    end
    chk("latency", 64'(lat), 64'(LAT));
    chk("bk1", 64'(bk1), 64'(e[0]));
    chk("bk2", 64'(bk2), 64'(e[1]));
    chk("bk3", 64'(bk3), 64'(e[2]));
    chk("bk4", 64'(bk4), 64'(e[3]));
    chk("res_max", io.res_max, emax);
    chk("res_step", 64'(io.res_step), 64'(exp_step));
    chk("res_last", 64'(io.res_last), 64'(last));
    chk("sym_err", 64'(sym_err), 64'(exp_err));
    io.res_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      cfg_we    = 1'b1;
      cfg_state = 2'($urandom_range(0, 3));
      cfg_sym   = SYM_W'($urandom_range(0, NSYM - 1));
      cfg_data  = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("stall_valid", 64'(io.res_valid), 64'(1));
      chk("stall_max", io.res_max, emax);
      chk("stall_step", 64'(io.res_step), 64'(exp_step));
      chk("stall_last", 64'(io.res_last), 64'(last));
      chk("stall_bk1", 64'(bk1), 64'(e[0]));
      chk("stall_bk4", 64'(bk4), 64'(e[3]));
    end
    cfg_we = 1'b0;
    io.res_ready = 1'b1;
    @(negedge clk);
    io.res_ready = 1'b0;
    chk("valid_after_hs", 64'(io.res_valid), 64'(0));
    chk("busy_after_hs", 64'(busy), 64'(0));
    if (exp_step == 0 || emax > exp_peak) begin
      exp_peak  = emax;
      exp_pstep = exp_step;
    end
    exp_step = last ? 0 : (exp_step + 1) % 256;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    io.obs_valid = 1'b0;
    io.obs_sym   = '0;
    io.obs_last  = 1'b0;
    io.res_ready = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;

    for (int j = 0; j < 4; j++)
      for (int s = 0; s < 4; s++)
        cfg_write(j, s, 32'(16 * j + s));
    run_obs(2, 1, 0, 0, 0, '0);
    chk("plan_bk3", 64'(bk3), 64'(34));

    run_obs(1, 0, 0, 0, 0, '0);
    run_obs(2, 0, 5, 0, 0, '0);
    run_obs(0, 1, 0, 0, 0, '0);
    run_obs(2, 1, 0, 0, 0, '0);

    cfg_write(1, 3, 32'hFFFF_FFFF);
    run_obs(1, 1, 0, 1, 2, 32'h8000_0001);
    run_obs(1, 1, 0, 1, 3, 32'h7FFF_FFFF);

    for (int it = 0; it < 20; it++) begin
      for (int w = 0; w < 2; w++)
        cfg_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++)
        run_obs($urandom_range(0, NSYM - 1), k == n - 1,
                $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                $urandom_range(0, 3), $urandom);
    end

    for (int i = 0; i < 258; i++)
      run_obs($urandom_range(0, NSYM - 1), i == 257, 0, 0, 0, '0);
    run_obs(0, 1, 0, 0, 0, '0);

    run_obs(3, 0, 1, 0, 0, '0);
    run_obs(1, 0, 0, 0, 0, '0);
    run_obs(2, 1, 2, 0, 0, '0);

    @(negedge clk);
    io.obs_valid = 1'b1;
    io.obs_sym   = SYM_W'(1);
    io.obs_last  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.obs_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    chk("ready_after_rst", 64'(io.obs_ready), 64'(1));
    run_obs(0, 0, 0, 0, 0, '0);
    run_obs(1, 0, 0, 0, 0, '0);
    run_obs(2, 1, 0, 0, 0, '0);

`ifdef HMM_SEQ_PEAK_EN
    force_mode = 1;
    force_val = 64'd10;
    run_obs(0, 0, 0, 0, 0, '0);
    force_val = 64'd40;
    run_obs(1, 0, 1, 0, 0, '0);
    force_val = 64'd25;
    run_obs(2, 1, 0, 0, 0, '0);
    chk("peak_max", peak_max, exp_peak);
    chk("peak_step", 64'(peak_step), 64'(exp_pstep));
    chk("peak_max_40", peak_max, 64'd40);
    force_val = 64'hFFFF_0000_0000_0005;
    run_obs(0, 0, 0, 0, 0, '0);
    force_val = 64'd3;
    run_obs(1, 1, 0, 0, 0, '0);
    chk("peak_restart_max", peak_max, exp_peak);
    chk("peak_restart_step", 64'(peak_step), 64'(exp_pstep));
    force_mode = 0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
